fifo_interface_buffer: RTL and testbench
========================================

# fifo_interface_buffer

Synchronous FIFO that buffers a ready/enable word stream between a producer and a consumer, using the same handshake convention on both sides. It is the standard elastic stage in the DA platform data paths: host command/response streams, memory command/read/write streams, and isolator slot data. All activity is in one clock domain.

## Interface

**Parameters**
- num_bits, default 16 — word width.
- log_depth, default 4 — log2 of the storage depth; depth = 2^log_depth words.

**Ports**
- clk  input  1  — clock; all logic samples on its rising edge.
- reset  input  1  — one clock; reset is synchronous and active-high.
- in_enable  input  1  — producer presents a valid word on in_data.
- in_data  input  num_bits  — write word.
- in_ready  output  1  — FIFO can accept a word this cycle.
- out_enable  output  1  — out_data holds a valid head word.
- out_data  output  num_bits  — head word, first-word-fall-through.
- out_ready  input  1  — consumer accepts the head word this cycle.
- count  output  log_depth+1  — number of words currently stored, 0..depth.

## Operation

- Handshake rule, both sides: a word transfers on a rising clk edge where ready and enable are both 1. No other edge transfers.
- Write: in_ready && in_enable stores in_data at the write pointer, and the write pointer advances.
- Read: out_ready && out_enable pops the head word, and the read pointer advances.
- Pointers are log_depth bits and wrap from depth-1 to 0. Fullness is tracked by count, or by an extra pointer MSB.
- in_ready = (count != depth). It is registered/derived from state only and does not depend on out_ready, so there is no combinational path between the two sides.
- out_enable = (count != 0). out_data = mem[read pointer]. Both come from state only and do not depend on in_enable.
- Simultaneous write and read in the same cycle:
  - count is unchanged; both pointers advance.
  - When full, only the read happens, because in_ready = 0.
  - When empty, only the write happens, because out_enable = 0. There is no bypass: a word written into an empty FIFO appears on out_data on the next cycle.
- count update: +1 on write only, −1 on read only, unchanged otherwise.
- in_data is ignored whenever in_ready = 0 or in_enable = 0.
- out_data is don't-care when out_enable = 0. The implementation holds the last array value; the verifier does not check it.
- Storage contents are not cleared by reset. Only pointers and count reset.

## Timing

- Reset: on any edge with reset = 1:
  - count = 0, both pointers = 0, in_ready = 1, out_enable = 0.
  - Any handshake on that same edge is ignored.
- Reset mid-operation discards all stored words. From the first edge after reset deasserts, the FIFO behaves as empty.
- Write-to-read latency is 1 cycle. A word written at edge N is visible with out_enable = 1 after edge N, and can be popped at edge N+1.
- Full/empty flags update in the cycle after the causing edge. There is no look-ahead.
- Throughput: with out_ready held at 1 and a continuous producer, one word per cycle is sustained indefinitely.
- Ordering is strictly FIFO. No words are lost or duplicated across pointer wrap-around.

## Test plan

1. **Reset values:** hold reset for 3 cycles with in_enable = 1 → in_ready = 1, out_enable = 0, count = 0, and no word is stored.
2. **Fill/full (log_depth = 2, depth 4):**
   - Write 0x0001..0x0004 with out_ready = 0 → count = 4, in_ready = 0.
   - A 5th write of 0x0005 is not accepted, and count stays 4.
3. **Drain order:** from the full state of test 2, set out_ready = 1 → the consumer receives 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, then out_enable = 0 and count = 0.
4. **Simultaneous read/write:**
   - With count = 2, perform one write and one read on the same edge → count stays 2, and the oldest word is popped.
   - With count = 4, assert both → only the read occurs, and count = 3.
5. **Wrap-around:** stream 0x0000..0x0013 (20 words) through depth 4 with out_ready = 1 → all 20 words are received in order, and the pointers have wrapped 5 times.
6. **Reset mid-stream:** with count = 3, assert reset for 1 cycle → count = 0 and out_enable = 0. A subsequent write of 0xA5A5 is the first word read out.

Source files
------------

// File: rtl/fifo_interface_buffer.sv
// First-word-fall-through synchronous FIFO with ready/enable handshakes on both sides.
// Flags come from stored state only, so there is no combinational path from one side to the other.
module fifo_interface_buffer #(
  parameter int num_bits  = 16,
  parameter int log_depth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_enable,
  input  logic [num_bits-1:0] in_data,
  output logic                in_ready,
  output logic                out_enable,
  output logic [num_bits-1:0] out_data,
  input  logic                out_ready,
  output logic [log_depth:0]  count
);
  localparam int DEPTH = 1 << log_depth;
  localparam logic [log_depth:0] FULL_CNT = (log_depth + 1)'(DEPTH);

  logic [num_bits-1:0]  mem_q [DEPTH];
  logic [log_depth-1:0] wr_ptr_q, wr_ptr_d;
  logic [log_depth-1:0] rd_ptr_q, rd_ptr_d;
  logic [log_depth:0]   count_q, count_d;
  logic                 wr_fire, rd_fire;

  assign in_ready   = (count_q != FULL_CNT);
  assign out_enable = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign count      = count_q;

  always_comb begin
    wr_fire  = in_ready && in_enable;
    rd_fire  = out_enable && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + log_depth'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + log_depth'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (log_depth + 1)'(1);
      2'b01:   count_d = count_q - (log_depth + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left uncleared by reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_fifo_interface_buffer.sv
// Scoreboard bench for fifo_interface_buffer at depth 4: directed plan followed by random traffic.
module tb_fifo_interface_buffer;
  localparam int NB    = 16;
  localparam int LD    = 2;
  localparam int DEPTH = 1 << LD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_enable = 1'b0;
  logic [NB-1:0] in_data = '0;
  logic          in_ready;
  logic          out_enable;
  logic [NB-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [LD:0]   count;

  int errors = 0;
  int checks = 0;
  int mdl_cnt = 0;
  int received = 0;
  bit mon_en = 1'b0;
  logic [NB-1:0] exp_q[$];

  fifo_interface_buffer #(.num_bits(NB), .log_depth(LD)) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_data(in_data),
    .in_ready(in_ready), .out_enable(out_enable), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just a queue whose length is bounded by DEPTH.
  always @(posedge clk) begin
    if (reset) begin
      mdl_cnt = 0;
      exp_q.delete();
      mon_en = 1'b1;
    end else begin
      bit wr, rd;
      wr = in_enable && (mdl_cnt < DEPTH);
      rd = out_ready && (mdl_cnt > 0);
      if (wr) exp_q.push_back(in_data);
      mdl_cnt = mdl_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    end
  end

  // Monitor: flags against the model, and each word presented with out_ready against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(mdl_cnt));
      chk("in_ready", 32'(in_ready), 32'(mdl_cnt != DEPTH));
      chk("out_enable", 32'(out_enable), 32'(mdl_cnt != 0));
      if (out_enable && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("pop_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          received++;
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit en, input logic [NB-1:0] d, input bit rdy);
    @(posedge clk);
    #2;
    reset = rst;
    in_enable = en;
    in_data = d;
    out_ready = rdy;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int rcv0;
    reset = 1'b1; in_enable = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0;
    repeat (2) drive(1, 1, 16'hDEAD, 0);
    drive(0, 0, 0, 0);
    settle();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_enable", 32'(out_enable), 32'd0);

    for (int i = 1; i <= 4; i++) drive(0, 1, NB'(i), 0);
    drive(0, 1, 16'h0005, 0);
    drive(0, 0, 0, 0);
    settle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    rcv0 = received;
    repeat (4) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    settle();
    chk("drain_received", 32'(received - rcv0), 32'd4);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_enable", 32'(out_enable), 32'd0);

    drive(0, 1, 16'h0101, 0);
    drive(0, 1, 16'h0202, 0);
    drive(0, 1, 16'h0303, 1);
    drive(0, 0, 0, 0);
    settle();
    chk("simul_count2", 32'(count), 32'd2);
    chk("simul_head", 32'(out_data), 32'h0202);
    drive(0, 1, 16'h0404, 0);
    drive(0, 1, 16'h0505, 0);
    drive(0, 1, 16'h0606, 1);
    drive(0, 0, 0, 0);
    settle();
    chk("simul_full_count", 32'(count), 32'd3);
    repeat (4) drive(0, 0, 0, 1);

    rcv0 = received;
    for (int i = 0; i < 20; i++) drive(0, 1, NB'(i), 1);
    repeat (3) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    settle();
    chk("wrap_received", 32'(received - rcv0), 32'd20);
    chk("wrap_count", 32'(count), 32'd0);

    for (int i = 0; i < 3; i++) drive(0, 1, NB'(16'h0C00 + i), 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    settle();
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_out_enable", 32'(out_enable), 32'd0);
    drive(0, 1, 16'hA5A5, 0);
    drive(0, 0, 0, 0);
    settle();
    chk("midreset_first", 32'(out_data), 32'hA5A5);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            NB'($urandom), ($urandom_range(0, 2) != 0));
    end
    drive(0, 0, 0, 1);
    repeat (DEPTH + 1) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    settle();
    chk("final_empty", 32'(count), 32'd0);
    chk("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
